// File: rtl/esc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : esc_pkg                                                           |
// | Shared types and sizing constants for the four-motor ESC pulse generator.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package esc_pkg;

  localparam int NUM_MOTORS = 4;
  localparam int THROTTLE_W = 8;

  typedef enum logic [1:0] {
    ARMING   = 2'd0,
    RUN      = 2'd1,
    FAILSAFE = 2'd2
  } esc_state_t;

  typedef logic [THROTTLE_W-1:0] throttle_t;

  // Widest pulse the arithmetic can produce, used for the elaboration check.
  function automatic longint max_pulse_cycles(input longint min_pulse, input longint step);
    return min_pulse + ((longint'(1) << THROTTLE_W) - 1) * step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esc_pulse_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : esc_pulse_channel                                                 |
// | One motor: active throttle register, pulse-width arithmetic, and the       |
// | registered compare against the shared frame counter.                       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module esc_pulse_channel
  import esc_pkg::*;
#(
  parameter int CNT_W            = 20,
  parameter int MIN_PULSE_CYCLES = 40000,
  parameter int STEP_CYCLES      = 157
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_force_zero,
  input  throttle_t        i_shadow,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pulse
);

  localparam logic [CNT_W-1:0] c_MIN  = CNT_W'(MIN_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] c_STEP = CNT_W'(STEP_CYCLES);

  throttle_t        r_active;
  logic             r_pulse;
  logic [CNT_W-1:0] w_pulse_cycles;

  // The top-level check guarantees the widest pulse is below the frame
  // length, so the counter width holds it without truncation.
  assign w_pulse_cycles = c_MIN + CNT_W'(r_active) * c_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      r_pulse  <= 1'b0;
    end else begin
      if (i_force_zero) begin
        r_active <= '0;
      end else if (i_load) begin
        r_active <= i_shadow;
      end
      r_pulse <= (i_cnt < w_pulse_cycles);
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/esc_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : esc_pwm_gen                                                       |
// | Four-channel servo-style ESC pulse generator with frame-aligned command    |
// | double buffering, power-up arming and loss-of-command failsafe.            |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module esc_pwm_gen
  import esc_pkg::*;
#(
  parameter int PERIOD_CYCLES    = 800000,
  parameter int MIN_PULSE_CYCLES = 40000,
  parameter int STEP_CYCLES      = 157,
  parameter int ARM_FRAMES       = 100,
  parameter int TIMEOUT_FRAMES   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MOTORS*THROTTLE_W-1:0] throttle_word,
  input  logic                             word_valid,
  output logic [NUM_MOTORS-1:0]            f_esc,
  output logic                             frame_start,
  output logic                             failsafe,
  output logic                             armed
);

  localparam int c_CNT_W = $clog2(PERIOD_CYCLES);
  localparam int c_ARM_W = $clog2(ARM_FRAMES + 1);
  localparam int c_WD_W  = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(ARM_FRAMES - 1);
  localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_FRAMES - 1);

  generate
    if (max_pulse_cycles(longint'(MIN_PULSE_CYCLES), longint'(STEP_CYCLES))
        >= longint'(PERIOD_CYCLES)) begin : g_bad_pulse_range
      $fatal(1, "esc_pwm_gen: MIN_PULSE_CYCLES + 255*STEP_CYCLES must be below PERIOD_CYCLES");
    end
    if ((ARM_FRAMES < 1) || (TIMEOUT_FRAMES < 1)) begin : g_bad_frame_counts
      $fatal(1, "esc_pwm_gen: ARM_FRAMES and TIMEOUT_FRAMES must be at least 1");
    end
  endgenerate

  logic [c_CNT_W-1:0]              r_cnt;
  logic [NUM_MOTORS*THROTTLE_W-1:0] r_shadow;
  esc_state_t                      r_state;
  logic [c_ARM_W-1:0]              r_arm_cnt;
  logic [c_WD_W-1:0]               r_wd;
  logic                            r_seen;
  logic                            r_frame_start;
  logic                            r_failsafe;
  logic                            r_armed;

  logic w_boundary;
  logic w_wd_expire;
  logic w_run_next;
  logic w_force_zero;

  assign w_boundary  = (r_cnt == c_CNT_LAST);
  assign w_wd_expire = !r_seen && (r_wd == c_WD_LAST);

  // Channels only follow the shadow when the frame after this boundary is RUN;
  // every other outcome (arming, entering or staying in failsafe) forces zero.
  assign w_run_next   = ((r_state == RUN) && !w_wd_expire) ||
                        ((r_state == FAILSAFE) && r_seen);
  assign w_force_zero = w_boundary && !w_run_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_state       <= ARMING;
      r_arm_cnt     <= '0;
      r_wd          <= '0;
      r_seen        <= 1'b0;
      r_frame_start <= 1'b0;
      r_failsafe    <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_frame_start <= (r_cnt == '0);

      if (word_valid) begin
        r_shadow <= throttle_word;
      end

      if (w_boundary) begin
        r_cnt  <= '0;
        // A word on the boundary cycle belongs to the frame that starts next.
        r_seen <= word_valid;
        case (r_state)
          ARMING: begin
            r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
            if (r_arm_cnt == c_ARM_LAST) begin
              r_state    <= RUN;
              r_armed    <= 1'b1;
              r_failsafe <= 1'b0;
            end
          end
          RUN: begin
            if (r_seen) begin
              r_wd <= '0;
            end else begin
              r_wd <= r_wd + c_WD_W'(1);
              if (w_wd_expire) begin
                r_state    <= FAILSAFE;
                r_failsafe <= 1'b1;
              end
            end
          end
          FAILSAFE: begin
            if (r_seen) begin
              r_state    <= RUN;
              r_wd       <= '0;
              r_failsafe <= 1'b0;
            end
          end
          default: begin
            r_state    <= ARMING;
            r_arm_cnt  <= '0;
            r_armed    <= 1'b0;
            r_failsafe <= 1'b0;
          end
        endcase
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
        if (word_valid) begin
          r_seen <= 1'b1;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_channel
      esc_pulse_channel #(
        .CNT_W            (c_CNT_W),
        .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES),
        .STEP_CYCLES      (STEP_CYCLES)
      ) u_channel (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_boundary),
        .i_force_zero (w_force_zero),
        .i_shadow     (r_shadow[i*THROTTLE_W +: THROTTLE_W]),
        .i_cnt        (r_cnt),
        .o_pulse      (f_esc[i])
      );
    end
  endgenerate

  assign frame_start = r_frame_start;
  assign failsafe    = r_failsafe;
  assign armed       = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_esc_pwm_gen                                                    |
// | Scoreboard bench: per-frame expectations queued by the stimulus, popped    |
// | and compared by a frame monitor at each following frame_start.             |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_esc_pwm_gen;

  localparam int P    = 1000;
  localparam int MINP = 100;
  localparam int STEP = 2;
  localparam int ARMF = 2;
  localparam int TOF  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] throttle_word = '0;
  logic        word_valid = 1'b0;
  logic [3:0]  f_esc;
  logic        frame_start;
  logic        failsafe;
  logic        armed;

  esc_pwm_gen #(
    .PERIOD_CYCLES    (P),
    .MIN_PULSE_CYCLES (MINP),
    .STEP_CYCLES      (STEP),
    .ARM_FRAMES       (ARMF),
    .TIMEOUT_FRAMES   (TOF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .throttle_word (throttle_word),
    .word_valid    (word_valid),
    .f_esc         (f_esc),
    .frame_start   (frame_start),
    .failsafe      (failsafe),
    .armed         (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w[4];
    bit armed;
    bit fs;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int w0, input int w1, input int w2, input int w3,
                              input bit a, input bit f);
    exp_t e;
    e.w[0] = w0; e.w[1] = w1; e.w[2] = w2; e.w[3] = w3;
    e.armed = a; e.fs = f;
    return e;
  endfunction

  // Frame monitor
  bit         m_in_frame = 1'b0;
  int         m_len;
  int         m_tot[4];
  int         m_run[4];
  bit         m_drop[4];
  bit         m_armed;
  bit         m_fs;
  int         m_frame = 0;
  logic [3:0] m_prev = '0;

  task automatic finalize_frame();
    exp_t e;
    bit   contig;
    chk($sformatf("f%0d expectation_available", m_frame), q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("f%0d frame_len", m_frame), m_len, P);
      contig = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("f%0d width_ch%0d", m_frame, i), m_tot[i], e.w[i]);
        if (m_run[i] != m_tot[i]) contig = 1'b0;
      end
      chk($sformatf("f%0d pulse_contiguous", m_frame), contig, 1);
      chk($sformatf("f%0d armed", m_frame), m_armed, e.armed);
      chk($sformatf("f%0d failsafe", m_frame), m_fs, e.fs);
    end
    m_frame++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_in_frame = 1'b0;
      end else if (frame_start) begin
        chk($sformatf("f%0d rise_with_frame_start", m_frame), {m_prev, f_esc}, 8'h0F);
        if (m_in_frame) finalize_frame();
        m_in_frame = 1'b1;
        m_len      = 1;
        m_armed    = armed;
        m_fs       = failsafe;
        for (int i = 0; i < 4; i++) begin
          m_tot[i]  = int'(f_esc[i]);
          m_run[i]  = int'(f_esc[i]);
          m_drop[i] = !f_esc[i];
        end
      end else if (m_in_frame) begin
        m_len++;
        for (int i = 0; i < 4; i++) begin
          if (f_esc[i]) begin
            m_tot[i]++;
            if (!m_drop[i]) m_run[i]++;
          end else begin
            m_drop[i] = 1'b1;
          end
        end
      end
      m_prev = f_esc;
    end
  end

  // Stimulus
  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < P + 20) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_within_bound", frame_start, 1);
  endtask

  // Called at the negedge where frame_start is high (cnt==1). A word placed at
  // offset c is sampled while cnt==c; c==P-1 is the boundary cycle.
  task automatic run_frame(input exp_t e, input int at1, input logic [31:0] w1,
                           input int at2, input logic [31:0] w2);
    q.push_back(e);
    for (int c = 1; c < P; c++) begin
      if (c == at1) begin
        word_valid    = 1'b1;
        throttle_word = w1;
      end else if (c == at2) begin
        word_valid    = 1'b1;
        throttle_word = w2;
      end else begin
        word_valid = 1'b0;
      end
      @(negedge clk);
    end
    word_valid = 1'b0;
    wait_fs();
  endtask

  initial begin
    exp_t idle0 = mk(100, 100, 100, 100, 1'b0, 1'b0);
    exp_t idle1 = mk(100, 100, 100, 100, 1'b1, 1'b0);
    exp_t fsafe = mk(100, 100, 100, 100, 1'b1, 1'b1);
    exp_t t2    = mk(338, 100, 610, 440, 1'b1, 1'b0);
    exp_t t3    = mk(356, 100, 100, 100, 1'b1, 1'b0);
    exp_t t3b   = mk(132, 100, 100, 100, 1'b1, 1'b0);
    exp_t t6    = mk(610, 610, 610, 610, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("reset_f_esc", f_esc, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_armed", armed, 0);
    chk("reset_failsafe", failsafe, 0);
    reset = 1'b0;
    wait_fs();

    // Arming, then first armed frame with an empty shadow
    run_frame(idle0, -1, '0, -1, '0);
    run_frame(idle0, -1, '0, -1, '0);
    run_frame(idle1, -1, '0, -1, '0);
    // Mid-frame word takes effect next frame
    run_frame(idle1, 500, 32'hAAFF0077, -1, '0);
    // Last word in a frame wins
    run_frame(t2, 200, 32'h0000_0001, 600, 32'h0000_0080);
    // Boundary-cycle word only reaches the channels a frame later
    run_frame(t3, P - 1, 32'h0000_0010, -1, '0);
    run_frame(t3, -1, '0, -1, '0);
    // Three empty frames then failsafe
    run_frame(t3b, -1, '0, -1, '0);
    run_frame(t3b, -1, '0, -1, '0);
    run_frame(t3b, -1, '0, -1, '0);
    run_frame(fsafe, -1, '0, -1, '0);
    run_frame(fsafe, 300, 32'hAAFF0077, -1, '0);
    run_frame(t2, -1, '0, -1, '0);

    // Asynchronous reset mid-pulse in the next (test-2) frame
    repeat (499) @(negedge clk);
    chk("pre_reset_f_esc2_high", f_esc[2], 1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_f_esc", f_esc, 0);
    chk("async_reset_armed", armed, 0);
    chk("async_reset_frame_start", frame_start, 0);
    chk("async_reset_failsafe", failsafe, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_fs();
    run_frame(idle0, -1, '0, -1, '0);
    run_frame(idle0, -1, '0, -1, '0);
    run_frame(idle1, 400, 32'hFFFF_FFFF, -1, '0);
    // Full-scale throttle: 610 high, 390 low
    run_frame(t6, -1, '0, -1, '0);

    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end of run, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
